shift_register_u: RTL and testbench
===================================

# shift_register_u

Parameterised universal shift register: the storage stage built directly on the team's edge-triggered D flip-flop. One clock, parallel load, hold, shift left/right with separate serial inputs. Adds a shift counter that flags each completed word (WIDTH shifts in one direction), so the block can act as a serial-to-parallel or parallel-to-serial converter feeding downstream lab logic.

## Interface
- WIDTH, default 4: register width; legal range 2–32.
- CLK  in  1  rising-edge clock for all state.
- RST_N  in  1  reset, asynchronous, active-low; asserts immediately, releases on the next CLK rising edge.
- MODE  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- SER_R  in  1  serial input entering Q[WIDTH-1] on shift right.
- SER_L  in  1  serial input entering Q[0] on shift left.
- P_IN  in  WIDTH  parallel load data.
- Q  out  WIDTH  register contents.
- SER_OUT_R  out  1  equals Q[0], the bit leaving on the next shift right.
- SER_OUT_L  out  1  equals Q[WIDTH-1], the bit leaving on the next shift left.
- SHIFT_CNT  out  $clog2(WIDTH)  shifts completed in the current word.
- WORD_DONE  out  1  one-cycle pulse: WIDTH consecutive same-direction shifts completed.

## Operation
- Reset values: Q = 0, SHIFT_CNT = 0, WORD_DONE = 0, internal LAST_DIR = right.
- MODE 00: Q, SHIFT_CNT and LAST_DIR hold. WORD_DONE = 0.
- MODE 01: Q <= {SER_R, Q[WIDTH-1:1]}.
- MODE 10: Q <= {Q[WIDTH-2:0], SER_L}.
- MODE 11: Q <= P_IN. SHIFT_CNT <= 0. WORD_DONE = 0. LAST_DIR unchanged.
- Shift counting, for MODE 01/10 with direction d:
  - d == LAST_DIR, SHIFT_CNT < WIDTH-1: SHIFT_CNT += 1.
  - d == LAST_DIR, SHIFT_CNT == WIDTH-1: SHIFT_CNT wraps to 0, WORD_DONE <= 1.
  - d != LAST_DIR: SHIFT_CNT <= 1, with no WORD_DONE. A direction change starts a new word, and this shift is its first bit. LAST_DIR <= d.
- For WIDTH not a power of two, SHIFT_CNT never exceeds WIDTH-1. The wrap is explicit, not natural overflow.
- WORD_DONE is registered and is high only in the cycle after the completing edge. It clears on the next edge unless that edge also completes a word. A word cannot complete in one cycle for WIDTH ≥ 2, so WORD_DONE never stays high for two consecutive cycles.
- SER_OUT_R/L are pure wires from Q. No extra register.

## Timing
- Every state change occurs on the CLK rising edge. Inputs are sampled at that edge, and results appear on Q the same cycle after the edge, with 1-cycle latency.
- MODE change takes effect at the next edge. There is no pipeline, and back-to-back mode changes are legal every cycle.
- Reset mid-word: Q, SHIFT_CNT and WORD_DONE clear asynchronously. The partial word is discarded.
- RST_N released and sampled low in the same edge: reset wins.
- SER_R/SER_L are ignored outside their own shift mode. P_IN is ignored outside MODE 11.

## Structure
- Shared package lab_pkg holds the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD, plus direction constants DIR_RIGHT and DIR_LEFT.
- Sub-module dff_rn: a single-bit D flip-flop with async active-low reset, instantiated WIDTH times for Q. The next-state mux is kept in the parent.
- Counter, LAST_DIR and WORD_DONE live in the parent as behavioural registers.

## Test plan
All scenarios use WIDTH=4.
- Reset: drive RST_N low mid-cycle with Q=1011 -> Q=0000, SHIFT_CNT=0 and WORD_DONE=0 immediately, without waiting for CLK.
- Load/hold: MODE=11, P_IN=1010, one edge -> Q=1010, SHIFT_CNT=0. Then MODE=00 for 3 edges -> Q stays 1010.
- Serial-in right: after reset, MODE=01 with SER_R sequence 1,0,1,1 over 4 edges -> Q=1101, SHIFT_CNT goes 1,2,3,0, WORD_DONE high only in the cycle after the 4th edge.
- Parallel-out left: load 1001, MODE=10, SER_L=0 -> SER_OUT_L across cycles is 1,0,0,1. Q ends at 0000 with WORD_DONE pulsed once.
- Direction change: 2 right shifts (SHIFT_CNT=2), then 1 left shift -> SHIFT_CNT=1, no WORD_DONE. Then 3 more left shifts -> WORD_DONE pulses.
- Load mid-word: 3 right shifts, then MODE=11 with P_IN=0110 -> Q=0110, SHIFT_CNT=0, no WORD_DONE. The next right shift gives SHIFT_CNT=1.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared encodings for the lab register blocks: operating modes and shift directions.
package lab_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

endpackage

// File: rtl/dff_rn.sv
// Single-bit edge-triggered D flip-flop with asynchronous active-low reset to 0.
module dff_rn (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/shift_register_u.sv
// Universal shift register (hold / shift right / shift left / load) built from dff_rn
// storage, with a per-word shift counter and a one-cycle word-complete pulse.
module shift_register_u
    import lab_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [1:0]               MODE,
    input  logic                     SER_R,
    input  logic                     SER_L,
    input  logic [WIDTH-1:0]         P_IN,
    output logic [WIDTH-1:0]         Q,
    output logic                     SER_OUT_R,
    output logic                     SER_OUT_L,
    output logic [$clog2(WIDTH)-1:0] SHIFT_CNT,
    output logic                     WORD_DONE
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    dir_e             last_dir_q;
    dir_e             last_dir_d;
    logic             word_done_q;
    logic             word_done_d;

    logic             is_shift;
    dir_e             shift_dir;

    always_comb begin
        q_d         = q_q;
        cnt_d       = cnt_q;
        last_dir_d  = last_dir_q;
        word_done_d = 1'b0;
        is_shift    = 1'b0;
        shift_dir   = DIR_RIGHT;

        unique case (mode_e'(MODE))
            MODE_HOLD: begin
            end
            MODE_SHR: begin
                q_d       = {SER_R, q_q[WIDTH-1:1]};
                is_shift  = 1'b1;
                shift_dir = DIR_RIGHT;
            end
            MODE_SHL: begin
                q_d       = {q_q[WIDTH-2:0], SER_L};
                is_shift  = 1'b1;
                shift_dir = DIR_LEFT;
            end
            MODE_LOAD: begin
                q_d   = P_IN;
                cnt_d = '0;
            end
            default: begin
            end
        endcase

        // A direction change opens a new word whose first bit is this shift.
        if (is_shift) begin
            if (shift_dir != last_dir_q) begin
                cnt_d      = CW'(1);
                last_dir_d = shift_dir;
            end else if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d       = '0;
                word_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            dff_rn u_dff (
                .clk   (CLK),
                .rst_n (RST_N),
                .d     (q_d[gi]),
                .q     (q_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q       <= '0;
            last_dir_q  <= DIR_RIGHT;
            word_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            last_dir_q  <= last_dir_d;
            word_done_q <= word_done_d;
        end
    end

    assign Q         = q_q;
    assign SER_OUT_R = q_q[0];
    assign SER_OUT_L = q_q[WIDTH-1];
    assign SHIFT_CNT = cnt_q;
    assign WORD_DONE = word_done_q;

endmodule

// File: tb/tb_shift_register_u.sv
// Randomised and directed checks of shift_register_u (WIDTH=4) against a run-length
// based reference model.
module tb_shift_register_u;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode  = 2'b00;
    logic         ser_r = 1'b0;
    logic         ser_l = 1'b0;
    logic [W-1:0] p_in  = '0;
    logic [W-1:0] q;
    logic         ser_out_r;
    logic         ser_out_l;
    logic [1:0]   shift_cnt;
    logic         word_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: value of the register, length of the current same-direction run.
    int m_q;
    int m_run;
    bit m_left;
    bit m_done;

    shift_register_u #(.WIDTH(W)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .MODE      (mode),
        .SER_R     (ser_r),
        .SER_L     (ser_l),
        .P_IN      (p_in),
        .Q         (q),
        .SER_OUT_R (ser_out_r),
        .SER_OUT_L (ser_out_l),
        .SHIFT_CNT (shift_cnt),
        .WORD_DONE (word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q    = 0;
        m_run  = 0;
        m_left = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_dir(input bit left);
        if (left != m_left) begin
            m_left = left;
            m_run  = 1;
        end else begin
            m_run++;
            if (m_run % W == 0) m_done = 1'b1;
        end
    endtask

    task automatic model_step(input int md, input int sr, input int sl, input int pin);
        m_done = 1'b0;
        case (md)
            1: begin
                m_q = (m_q / 2) + sr * (1 << (W - 1));
                model_dir(1'b0);
            end
            2: begin
                m_q = ((m_q * 2) % (1 << W)) + sl;
                model_dir(1'b1);
            end
            3: begin
                m_q   = pin;
                m_run = 0;
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},     32'(q),         32'(m_q));
        check({tag, ".sor"},   32'(ser_out_r), 32'(m_q % 2));
        check({tag, ".sol"},   32'(ser_out_l), 32'((m_q >> (W - 1)) % 2));
        check({tag, ".cnt"},   32'(shift_cnt), 32'(m_run % W));
        check({tag, ".done"},  32'(word_done), 32'(m_done));
    endtask

    // Apply one operation, clock it, check one step after the edge.
    task automatic cycle(input string tag, input int md, input int sr, input int sl, input int pin);
        mode  = 2'(md);
        ser_r = 1'(sr);
        ser_l = 1'(sl);
        p_in  = W'(pin);
        @(posedge clk);
        model_step(md, sr, sl, pin);
        #1;
        check_all(tag);
        $display("txn %-8s mode=%0d sr=%0d sl=%0d p=%h -> q=%h cnt=%0d done=%0d",
                 tag, md, sr, sl, pin, q, shift_cnt, word_done);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Load / hold
        cycle("load", 3, 0, 0, 4'b1010);
        check("load_q", 32'(q), 32'b1010);
        for (int i = 0; i < 3; i++) cycle("hold", 0, 1, 1, 4'b0101);
        check("hold_q", 32'(q), 32'b1010);

        // Async reset with Q=1011
        cycle("ld1011", 3, 0, 0, 4'b1011);
        async_reset("arst");
        check("arst_q", 32'(q), 32'd0);

        // Serial-in right 1,0,1,1
        cycle("shr1", 1, 1, 0, 0);
        check("shr1_cnt", 32'(shift_cnt), 32'd1);
        cycle("shr2", 1, 0, 1, 0);
        cycle("shr3", 1, 1, 0, 0);
        cycle("shr4", 1, 1, 1, 0);
        check("sin_q", 32'(q), 32'b1101);
        check("sin_done", 32'(word_done), 32'd1);
        cycle("hold", 0, 0, 0, 0);
        check("sin_done_clr", 32'(word_done), 32'd0);

        // Parallel-out left
        cycle("ld1001", 3, 0, 0, 4'b1001);
        for (int i = 0; i < 4; i++) cycle("shl", 2, 1, 0, 4'b1111);
        check("pout_q", 32'(q), 32'd0);
        check("pout_done", 32'(word_done), 32'd1);

        // Direction change
        cycle("ld0000", 3, 0, 0, 0);
        cycle("dc_r1", 1, 1, 0, 0);
        cycle("dc_r2", 1, 0, 0, 0);
        check("dc_cnt2", 32'(shift_cnt), 32'd2);
        cycle("dc_l1", 2, 0, 1, 0);
        check("dc_cnt1", 32'(shift_cnt), 32'd1);
        check("dc_nodone", 32'(word_done), 32'd0);
        for (int i = 0; i < 3; i++) cycle("dc_l", 2, 0, 1, 0);
        check("dc_done", 32'(word_done), 32'd1);

        // Load mid-word
        for (int i = 0; i < 3; i++) cycle("mw_r", 1, 1, 0, 0);
        cycle("mw_ld", 3, 0, 0, 4'b0110);
        check("mw_q", 32'(q), 32'b0110);
        check("mw_cnt", 32'(shift_cnt), 32'd0);
        cycle("mw_r1", 1, 0, 0, 0);
        check("mw_cnt1", 32'(shift_cnt), 32'd1);

        // Random traffic, biased toward shifts, with occasional async resets
        for (int i = 0; i < 400; i++) begin
            int md;
            md = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 3));
            if ($urandom_range(0, 60) == 0) begin
                async_reset("rnd_rst");
            end else begin
                cycle("rnd", md, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      int'($urandom_range(0, (1 << W) - 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
